enc_key_sequencer: RTL and testbench
====================================

ENC_KEY_SEQUENCER -- requirements
Module: enc_key_sequencer

Interface
REQ-001 Parameter: ROUNDS, default 64, number of round subkeys produced per key load.
REQ-002 Parameter: KEY_SIZE, default 256, master key width; SIDE_SIZE, default 128, subkey width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to load key_in and begin a subkey sequence.
REQ-006 key_in  input  KEY_SIZE  master key, MSB-first bit order [0:KEY_SIZE-1].
REQ-007 busy  output  1  high while a sequence is in progress.
REQ-008 sk_valid  output  1  sk_out holds a valid round subkey.
REQ-009 sk_ready  input  1  consumer accepts sk_out this cycle.
REQ-010 sk_out  output  SIDE_SIZE  current round subkey, [0:SIDE_SIZE-1].
REQ-011 sk_round  output  clog2(ROUNDS)  round index of sk_out, 0-based.
REQ-012 done  output  1  one-cycle pulse after the final subkey is accepted.

Function
REQ-013 States: IDLE, RUN; reset state IDLE.
REQ-014 IDLE: busy=0, sk_valid=0; start=1 loads key_reg<=key_in, delta_reg<=0, round<=0, goes to RUN.
REQ-015 Latency: start accepted in cycle T -> sk_valid=1 with round-0 subkey in cycle T+1.
REQ-016 RUN: busy=1, sk_valid=1; sk_out = SWAN256 round subkey computed from key_reg and delta_reg (rotate key right by 120, delta' = delta + DELTA0 mod 2^128, sk = low 128 bits of rotated key + delta' mod 2^128).
REQ-017 Handshake: transfer occurs when sk_valid & sk_ready; only then key_reg<=next_key, delta_reg<=next_delta, round<=round+1.
REQ-018 sk_ready=0 in RUN: key_reg, delta_reg, round, sk_out held stable indefinitely.
REQ-019 Transfer with round==ROUNDS-1: next cycle state IDLE, done=1 for exactly that cycle, sk_valid=0.
REQ-020 start while busy=1: ignored, no effect on state or outputs.
REQ-021 start asserted in the done cycle: accepted (state is IDLE), new sequence begins normally.
REQ-022 Round counter never wraps within a sequence; sk_round = round register.
REQ-023 All additions modulo 2^SIDE_SIZE, carries discarded; no combinational path from key_in or start to any output.

Reset
REQ-024 rst=1 forces immediately: state IDLE, busy=0, sk_valid=0, done=0, round=0, key_reg=0, delta_reg=0, sk_out=0.
REQ-025 rst during RUN aborts the sequence; no done pulse is generated.
REQ-026 After rst deassertion, first start is accepted on the first rising edge.

Structure
REQ-027 Shared package swan256_pkg holds KEY_SIZE, SIDE_SIZE, PD=120, DELTA0=128'h9e3779b97f4a7c15f39cc0605cedc834, ROUNDS default.
REQ-028 Single sub-module instance enc_key_schedule computes next_key, next_delta and sk combinationally from key_reg and delta_reg.
REQ-029 sk_out is driven from that instance's sk output, gated to 0 when sk_valid=0.

Verification
REQ-030 key_in=0, start, sk_ready=1 -> T+1: sk_valid=1, sk_round=0, sk_out=9e3779b97f4a7c15f39cc0605cedc834; T+2: sk_round=1, sk_out=3c6ef372fe94f82be73980c0b9db9106.
REQ-031 Random key, sk_ready=1 continuously -> exactly 64 subkeys, sk_round 0..63, all matching the golden model; done pulses once, in the cycle after round 63 is accepted.
REQ-032 Random sk_ready stalls -> sk_out/sk_round stable while stalled; the subkey sequence is identical to the no-stall run.
REQ-033 start pulsed mid-sequence with a different key_in -> ignored; sequence continues with the original key.
REQ-034 rst asserted at round 20, between clock edges -> outputs zero immediately, no done pulse; a fresh start reproduces round 0 correctly.
REQ-035 start held high through the done cycle -> a second sequence starts back-to-back with round 0 in the following cycle.

Source files
------------

// File: rtl/swan256_pkg.sv
// Shared constants and state encoding for the SWAN256 round-key sequencer.
// Holds the key geometry, the rotation distance and the golden-ratio delta seed.
package swan256_pkg;

    localparam int KEY_SIZE       = 256;
    localparam int SIDE_SIZE      = 128;
    localparam int PD             = 120;
    localparam int ROUNDS_DEFAULT = 64;

    localparam logic [127:0] DELTA0 = 128'h9e3779b97f4a7c15f39cc0605cedc834;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/enc_key_schedule.sv
// One SWAN256 key-schedule step: rotate the key, advance delta, derive the subkey.
// The subkey is written back into the low half of the key for the following round.
module enc_key_schedule
    import swan256_pkg::*;
#(
    parameter int KEY_SIZE  = swan256_pkg::KEY_SIZE,
    parameter int SIDE_SIZE = swan256_pkg::SIDE_SIZE
) (
    input  logic [KEY_SIZE-1:0]  key,
    input  logic [SIDE_SIZE-1:0] delta,
    output logic [KEY_SIZE-1:0]  next_key,
    output logic [SIDE_SIZE-1:0] next_delta,
    output logic [SIDE_SIZE-1:0] sk
);

    logic [KEY_SIZE-1:0] rot_s;

    // rotate right by PD, then add the advanced delta into the low half
    always_comb begin
        rot_s      = (key >> PD) | (key << (KEY_SIZE - PD));
        next_delta = delta + SIDE_SIZE'(DELTA0);
        sk         = rot_s[SIDE_SIZE-1:0] + next_delta;
        next_key   = {rot_s[KEY_SIZE-1:SIDE_SIZE], sk};
    end

endmodule

// File: rtl/enc_key_sequencer.sv
// Loads a master key on start and streams ROUNDS subkeys over a valid/ready
// handshake, pulsing done for one cycle after the last subkey is accepted.
module enc_key_sequencer
    import swan256_pkg::*;
#(
    parameter int ROUNDS    = swan256_pkg::ROUNDS_DEFAULT,
    parameter int KEY_SIZE  = swan256_pkg::KEY_SIZE,
    parameter int SIDE_SIZE = swan256_pkg::SIDE_SIZE,
    localparam int RW       = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [0:KEY_SIZE-1]  key_in,
    output logic                 busy,
    output logic                 sk_valid,
    input  logic                 sk_ready,
    output logic [0:SIDE_SIZE-1] sk_out,
    output logic [RW-1:0]        sk_round,
    output logic                 done
);

    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

    seq_state_t           state_r, state_s;
    logic [KEY_SIZE-1:0]  key_r, key_s;
    logic [SIDE_SIZE-1:0] delta_r, delta_s;
    logic [RW-1:0]        round_r, round_s;
    logic                 done_r, done_s;

    logic [KEY_SIZE-1:0]  next_key_s;
    logic [SIDE_SIZE-1:0] next_delta_s;
    logic [SIDE_SIZE-1:0] sk_s;

    enc_key_schedule #(
        .KEY_SIZE  (KEY_SIZE),
        .SIDE_SIZE (SIDE_SIZE)
    ) u_schedule (
        .key        (key_r),
        .delta      (delta_r),
        .next_key   (next_key_s),
        .next_delta (next_delta_s),
        .sk         (sk_s)
    );

    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            key_r   <= {KEY_SIZE{1'b0}};
            delta_r <= {SIDE_SIZE{1'b0}};
            round_r <= {RW{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            key_r   <= key_s;
            delta_r <= delta_s;
            round_r <= round_s;
            done_r  <= done_s;
        end
    end

    // next-state: load on start in IDLE, advance only on an accepted transfer
    always_comb begin
        state_s = state_r;
        key_s   = key_r;
        delta_s = delta_r;
        round_s = round_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    key_s   = key_in;
                    delta_s = {SIDE_SIZE{1'b0}};
                    round_s = {RW{1'b0}};
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (sk_ready) begin
                    key_s   = next_key_s;
                    delta_s = next_delta_s;
                    if (round_r == LAST_ROUND) begin
                        // round stays at its last value; it is reloaded on the next start
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        round_s = round_r + RW'(1'b1);
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state_r == ST_RUN);
    assign sk_valid = (state_r == ST_RUN);
    assign sk_round = round_r;
    assign done     = done_r;

    // subkey forced to zero whenever it is not valid
    always_comb begin
        if (state_r == ST_RUN) begin
            sk_out = sk_s;
        end else begin
            sk_out = {SIDE_SIZE{1'b0}};
        end
    end

endmodule

// File: tb/tb_enc_key_sequencer.sv
// Directed self-checking bench for enc_key_sequencer with an independent
// bit-level model of the SWAN256 key schedule.
module tb_enc_key_sequencer;

    localparam int ROUNDS    = 64;
    localparam int KEY_SIZE  = 256;
    localparam int SIDE_SIZE = 128;
    localparam int RW        = 6;
    localparam logic [127:0] DELTA_C = 128'h9e3779b97f4a7c15f39cc0605cedc834;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 sk_ready = 1'b0;
    logic [0:KEY_SIZE-1]  key_in = {KEY_SIZE{1'b0}};
    logic                 busy;
    logic                 sk_valid;
    logic [0:SIDE_SIZE-1] sk_out;
    logic [RW-1:0]        sk_round;
    logic                 done;

    int checks = 0;
    int errors = 0;

    logic [127:0] obs_log [ROUNDS];
    logic [127:0] ref_log [ROUNDS];
    logic [255:0] key1, key2;

    always #5 clk = ~clk;

    enc_key_sequencer #(
        .ROUNDS    (ROUNDS),
        .KEY_SIZE  (KEY_SIZE),
        .SIDE_SIZE (SIDE_SIZE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .sk_valid (sk_valid),
        .sk_ready (sk_ready),
        .sk_out   (sk_out),
        .sk_round (sk_round),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [255:0] k, input logic [127:0] d,
                              output logic [255:0] nk, output logic [127:0] nd,
                              output logic [127:0] sk);
        logic [255:0] r;
        for (int i = 0; i < 256; i++) r[i] = k[(i + 120) % 256];
        nd = d + DELTA_C;
        sk = r[127:0] + nd;
        nk = {r[255:128], sk};
    endtask

    task automatic run_seq(input logic [255:0] key, input int stall_pct, input int inj_round,
                           input int abort_round, input bit hold_start, input bit pre_started,
                           input logic [255:0] follow_key);
        logic [255:0] mk, nk;
        logic [127:0] md, nd, esk, cur;
        int  r = 0;
        int  cyc = 0;
        bit  rdy;
        bit  injected = 1'b0;
        if (!pre_started) begin
            key_in = key;
            start  = 1'b1;
        end
        sk_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        mk = key;
        md = 128'h0;
        while (r < ROUNDS && cyc < 1000) begin
            model_step(mk, md, nk, nd, esk);
            cur = sk_out;
            chk($sformatf("valid r%0d", r), 256'(sk_valid), 256'(1'b1));
            chk($sformatf("busy r%0d", r), 256'(busy), 256'(1'b1));
            chk($sformatf("round r%0d", r), 256'(sk_round), 256'(r));
            chk($sformatf("sk r%0d", r), 256'(cur), 256'(esk));
            chk($sformatf("no_done r%0d", r), 256'(done), 256'(1'b0));
            if (r == abort_round) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_valid", 256'(sk_valid), 256'(1'b0));
                chk("rst_busy", 256'(busy), 256'(1'b0));
                chk("rst_sk", 256'(sk_out), 256'(0));
                chk("rst_round", 256'(sk_round), 256'(0));
                chk("rst_done", 256'(done), 256'(1'b0));
                start = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("post_rst_done", 256'(done), 256'(1'b0));
                    chk("post_rst_busy", 256'(busy), 256'(1'b0));
                end
                return;
            end
            rdy = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(0, 99)) >= stall_pct);
            sk_ready = rdy;
            if (r == inj_round && !injected) begin
                start    = 1'b1;
                key_in   = ~key;
                injected = 1'b1;
            end else if (hold_start && r == ROUNDS - 1) begin
                start  = 1'b1;
                key_in = follow_key;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (rdy) begin
                obs_log[r] = cur;
                mk = nk;
                md = nd;
                r++;
            end
            cyc++;
        end
        if (r < ROUNDS) chk("timeout_rounds", 256'(r), 256'(ROUNDS));
        chk("done_pulse", 256'(done), 256'(1'b1));
        chk("done_valid", 256'(sk_valid), 256'(1'b0));
        chk("done_busy", 256'(busy), 256'(1'b0));
        chk("done_sk", 256'(sk_out), 256'(0));
        if (!hold_start) begin
            @(negedge clk);
            chk("done_once", 256'(done), 256'(1'b0));
            chk("idle_busy", 256'(busy), 256'(1'b0));
        end
    endtask

    initial begin
        @(negedge clk);
        chk("reset_busy", 256'(busy), 256'(1'b0));
        chk("reset_valid", 256'(sk_valid), 256'(1'b0));
        chk("reset_done", 256'(done), 256'(1'b0));
        chk("reset_sk", 256'(sk_out), 256'(0));
        chk("reset_round", 256'(sk_round), 256'(0));
        rst = 1'b0;

        // zero key: first two subkeys are hand-computed
        run_seq(256'h0, 0, -1, -1, 1'b0, 1'b0, 256'h0);
        chk("zero_key_r0", 256'(obs_log[0]), 256'(128'h9e3779b97f4a7c15f39cc0605cedc834));
        chk("zero_key_r1", 256'(obs_log[1]), 256'(128'h3c6ef372fe94f82be73980c0b9db9106));

        key1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        key2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};

        run_seq(key1, 0, -1, -1, 1'b0, 1'b0, 256'h0);
        ref_log = obs_log;

        // random stalls must give the identical sequence
        run_seq(key1, 40, -1, -1, 1'b0, 1'b0, 256'h0);
        for (int i = 0; i < ROUNDS; i++)
            chk($sformatf("stall_seq r%0d", i), 256'(obs_log[i]), 256'(ref_log[i]));

        // start mid-sequence with another key is ignored
        run_seq(key1, 0, 10, -1, 1'b0, 1'b0, 256'h0);
        for (int i = 0; i < ROUNDS; i++)
            chk($sformatf("inject_seq r%0d", i), 256'(obs_log[i]), 256'(ref_log[i]));

        // reset at round 20, then a fresh start
        run_seq(key1, 0, -1, 20, 1'b0, 1'b0, 256'h0);
        run_seq(key1, 0, -1, -1, 1'b0, 1'b0, 256'h0);
        chk("fresh_r0", 256'(obs_log[0]), 256'(ref_log[0]));

        // start held through done: back-to-back second sequence
        run_seq(key1, 0, -1, -1, 1'b1, 1'b0, key2);
        run_seq(key2, 0, -1, -1, 1'b0, 1'b1, 256'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
